draw_menu_cursor: RTL
=====================

Name: draw_menu_cursor

Overview:
- Pipeline stage placed directly downstream of the menu drawing stage.
- Consumes its registered VGA timing bundle and pixel colour.
- Overlays a selection frame around the currently highlighted menu item.
- Runs the menu-selection state machine: up/down/select pulses move the highlight and report the chosen item to the game controller.

Parameters:
- N_ITEMS, 3, number of stacked menu items (2..4).
- ITEM_X, 412, left x of every item rectangle.
- ITEM_Y0, 200, top y of item 0.
- ITEM_W, 200, item width in pixels.
- ITEM_H, 80, item height in pixels.
- ITEM_PITCH, 120, vertical distance between item tops.
- FRAME_T, 4, frame thickness drawn outside the item rectangle.
- FRAME_COLOR, 12'hF00, frame colour.
- CONFIRM_FRAMES, 32, frames spent in CONFIRM before reporting.
- BLINK_FRAMES, 8, blink half-period in frames.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  reset; synchronous, active-low.
- vga_in  vga_if.in  -  hcount/vcount (11 b), hsync, vsync, hblnk, vblnk from the menu drawing stage.
- rgb_i  in  RGB_B  pixel colour from the menu drawing stage.
- btn_up  in  1  debounced single-cycle pulse.
- btn_down  in  1  debounced single-cycle pulse.
- btn_sel  in  1  debounced single-cycle pulse.
- menu_en  in  1  menu screen active.
- vga_out  vga_if.out  -  vga_in delayed 1 cycle.
- rgb_o  out  RGB_B  output pixel.
- sel_idx  out  2  current highlighted item.
- sel_valid  out  1  one-cycle pulse: sel_idx is the confirmed choice.

Behaviour:
- Reset (rst==0 at clk edge):
  - vga_out fields all 0, rgb_o=0, sel_idx=0, sel_valid=0.
  - State BROWSE; pending flags, frame counter and blink phase all cleared.
- Pipeline:
  - All vga_out fields and rgb_o are registered with fixed 1-cycle latency.
  - The timing fields are copied unchanged.
- Frame start: cycle where vga_in.hcount==0 and vga_in.vcount==0.
- Frame region for item k:
  - Outer box: x in [ITEM_X-FRAME_T, ITEM_X+ITEM_W+FRAME_T), y in [Yk-FRAME_T, Yk+ITEM_H+FRAME_T), with Yk=ITEM_Y0+k*ITEM_PITCH.
  - The inner item rectangle is excluded.
  - Compare in 12-bit unsigned arithmetic; parameters guarantee no underflow.
- rgb_o selection:
  - rgb_o=FRAME_COLOR when all hold: pixel is in the frame of sel_idx, hblnk==0, vblnk==0, menu_en==1, frame visible.
  - Otherwise rgb_o=rgb_i.
- Move requests:
  - btn_up or btn_down sets a pending flag.
  - Pending moves are applied only at frame start, so the highlight never tears mid-frame.
  - Up: idx 0 wraps to N_ITEMS-1; otherwise idx-1.
  - Down: idx N_ITEMS-1 wraps to 0; otherwise idx+1.
  - Multiple pulses of the same direction within one frame collapse into one step.
  - btn_up and btn_down asserted in the same cycle: both ignored.
  - Both flags pending at frame start: both cleared, no move.
- FSM:
  - BROWSE:
    - Moves accepted; frame visible (solid).
    - btn_sel goes to CONFIRM: clears pending moves and the frame counter.
    - If btn_sel and a move pulse arrive in the same cycle, btn_sel wins and the move is dropped.
  - CONFIRM:
    - Moves and btn_sel ignored.
    - Frame counter increments at each frame start.
    - Frame visible when (counter / BLINK_FRAMES) is even.
    - When the counter reaches CONFIRM_FRAMES: sel_valid=1 for exactly one cycle, sel_idx held, go to DONE.
  - DONE:
    - Frame solid; all buttons ignored; sel_idx held.
- menu_en==0 (any state):
  - Next cycle: state BROWSE, sel_idx=0, pending cleared, sel_valid=0.
  - rgb_o = rgb_i (pass-through).
- Reset mid-CONFIRM: no sel_valid is ever emitted for the aborted selection.

Optional Feature:
- Macro: MENU_IDLE_BLINK_EN.
- Defined: in BROWSE the frame blinks. Visible when (free-running frame count / (2*BLINK_FRAMES)) is even, i.e. slow idle blink. The count resets to 0 on every accepted move, so the frame is visible immediately after moving.
- Undefined: BROWSE frame is solid.
- CONFIRM and DONE behaviour is identical in both builds.

Test Plan:
1. Reset, menu_en=1, idx 0. Drive pixel (410,198) with rgb_i=12'h0AA -> rgb_o=12'hF00 one cycle later. Pixel (412,200) -> 12'h0AA. Pixel (410,198) during hblnk=1 -> rgb_i.
2. btn_down pulse at vcount=300 -> sel_idx stays 0 until next frame start, then 1. Pixel (412,316) -> 12'hF00; (410,198) -> rgb_i.
3. Wrap and collisions:
   - From idx 0, btn_up -> idx 2 after frame start.
   - btn_up and btn_down in the same cycle -> idx unchanged.
   - Three btn_down pulses in one frame -> idx advances by 1 only.
4. idx 1, btn_sel:
   - Frame hidden during CONFIRM counts 8..15 and 24..31.
   - Exactly one sel_valid cycle with sel_idx=1 at count 32.
   - btn_down during CONFIRM/DONE -> no change.
5. rst=0 at CONFIRM count 10 -> all outputs 0 next cycle; no sel_valid pulse over the following 40 frames.
6. menu_en low in DONE -> BROWSE, sel_idx=0, rgb_o==rgb_i. Re-enable, btn_sel -> new sel_valid after 32 frames with sel_idx=0.

Source files
------------

// File: rtl/draw_menu_cursor_if.sv
// VGA timing bundle passed between drawing stages; hcount/vcount are 11-bit pixel coordinates.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;

  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk);
  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk);
endinterface

// File: rtl/draw_menu_cursor.sv
// Menu cursor stage: 1-cycle registered overlay of a selection frame plus the BROWSE/CONFIRM/DONE selection FSM.
// Optional macro MENU_IDLE_BLINK_EN makes the BROWSE frame blink slowly instead of staying solid.
module draw_menu_cursor #(
  parameter int               N_ITEMS        = 3,
  parameter int               ITEM_X         = 412,
  parameter int               ITEM_Y0        = 200,
  parameter int               ITEM_W         = 200,
  parameter int               ITEM_H         = 80,
  parameter int               ITEM_PITCH     = 120,
  parameter int               FRAME_T        = 4,
  parameter int               RGB_B          = 12,
  parameter logic [RGB_B-1:0] FRAME_COLOR    = 12'hF00,
  parameter int               CONFIRM_FRAMES = 32,
  parameter int               BLINK_FRAMES   = 8
) (
  input  logic             clk,
  input  logic             rst,
  vga_if.in                vga_in,
  input  logic [RGB_B-1:0] rgb_i,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_sel,
  input  logic             menu_en,
  vga_if.out               vga_out,
  output logic [RGB_B-1:0] rgb_o,
  output logic [1:0]       sel_idx,
  output logic             sel_valid
);

  localparam int CW = $clog2(CONFIRM_FRAMES + 1);

  typedef enum logic [1:0] {BROWSE, CONFIRM, DONE} state_t;

  state_t        state;
  logic          pend_up;
  logic          pend_down;
  logic [CW-1:0] cnt;

  logic        frame_start;
  logic        up_req;
  logic        dn_req;
  logic        move_apply;
  logic [1:0]  idx_up;
  logic [1:0]  idx_dn;
  logic [11:0] px;
  logic [11:0] py;
  logic [11:0] yk;
  logic        in_outer;
  logic        in_inner;
  logic        browse_vis;
  logic        frame_vis;
  logic        draw_frame;

  assign frame_start = (vga_in.hcount == 11'd0) && (vga_in.vcount == 11'd0);
  // Opposite directions in the same cycle cancel each other out.
  assign up_req      = btn_up & ~btn_down;
  assign dn_req      = btn_down & ~btn_up;
  assign move_apply  = menu_en && (state == BROWSE) && !btn_sel && frame_start
                       && (pend_up ^ pend_down);

  assign idx_up = (sel_idx == 2'd0) ? 2'(N_ITEMS - 1) : sel_idx - 2'd1;
  assign idx_dn = (sel_idx == 2'(N_ITEMS - 1)) ? 2'd0 : sel_idx + 2'd1;

  assign px = {1'b0, vga_in.hcount};
  assign py = {1'b0, vga_in.vcount};
  assign yk = 12'(ITEM_Y0) + 12'(sel_idx) * 12'(ITEM_PITCH);

  assign in_outer = (px >= 12'(ITEM_X - FRAME_T)) && (px < 12'(ITEM_X + ITEM_W + FRAME_T))
                 && (py >= yk - 12'(FRAME_T)) && (py < yk + 12'(ITEM_H + FRAME_T));
  assign in_inner = (px >= 12'(ITEM_X)) && (px < 12'(ITEM_X + ITEM_W))
                 && (py >= yk) && (py < yk + 12'(ITEM_H));

`ifdef MENU_IDLE_BLINK_EN
  localparam int IW = $clog2(4 * BLINK_FRAMES);
  logic [IW-1:0] idle_cnt;
  assign browse_vis = ((32'(idle_cnt) / (2 * BLINK_FRAMES)) % 2) == 0;
`else
  assign browse_vis = 1'b1;
`endif

  always_comb begin
    frame_vis = 1'b1;
    case (state)
      BROWSE:  frame_vis = browse_vis;
      CONFIRM: frame_vis = ((32'(cnt) / BLINK_FRAMES) % 2) == 0;
      default: frame_vis = 1'b1;
    endcase
  end

  assign draw_frame = in_outer && !in_inner && !vga_in.hblnk && !vga_in.vblnk
                   && menu_en && frame_vis;

  always_ff @(posedge clk) begin
    if (!rst) begin
      vga_out.hcount <= '0;
      vga_out.vcount <= '0;
      vga_out.hsync  <= 1'b0;
      vga_out.vsync  <= 1'b0;
      vga_out.hblnk  <= 1'b0;
      vga_out.vblnk  <= 1'b0;
      rgb_o          <= '0;
      sel_idx        <= 2'd0;
      sel_valid      <= 1'b0;
      state          <= BROWSE;
      pend_up        <= 1'b0;
      pend_down      <= 1'b0;
      cnt            <= '0;
`ifdef MENU_IDLE_BLINK_EN
      idle_cnt       <= '0;
`endif
    end else begin
      vga_out.hcount <= vga_in.hcount;
      vga_out.vcount <= vga_in.vcount;
      vga_out.hsync  <= vga_in.hsync;
      vga_out.vsync  <= vga_in.vsync;
      vga_out.hblnk  <= vga_in.hblnk;
      vga_out.vblnk  <= vga_in.vblnk;
      rgb_o          <= draw_frame ? FRAME_COLOR : rgb_i;
      sel_valid      <= 1'b0;
`ifdef MENU_IDLE_BLINK_EN
      if (frame_start)
        idle_cnt <= move_apply ? '0 : idle_cnt + IW'(1);
`endif
      if (!menu_en) begin
        state     <= BROWSE;
        sel_idx   <= 2'd0;
        pend_up   <= 1'b0;
        pend_down <= 1'b0;
        cnt       <= '0;
      end else begin
        case (state)
          BROWSE: begin
            if (btn_sel) begin
              state     <= CONFIRM;
              pend_up   <= 1'b0;
              pend_down <= 1'b0;
              cnt       <= '0;
            end else if (frame_start) begin
              // Both directions pending cancel; a pulse in this cycle queues for the next frame.
              if (pend_up && !pend_down)
                sel_idx <= idx_up;
              else if (pend_down && !pend_up)
                sel_idx <= idx_dn;
              pend_up   <= up_req;
              pend_down <= dn_req;
            end else begin
              pend_up   <= pend_up | up_req;
              pend_down <= pend_down | dn_req;
            end
          end
          CONFIRM: begin
            if (frame_start) begin
              if (cnt == CW'(CONFIRM_FRAMES - 1)) begin
                cnt       <= CW'(CONFIRM_FRAMES);
                sel_valid <= 1'b1;
                state     <= DONE;
              end else begin
                cnt <= cnt + CW'(1);
              end
            end
          end
          DONE: ;
          default: state <= BROWSE;
        endcase
      end
    end
  end

endmodule
